// File: rtl/reg_bank_rw.sv
// 32-entry register file with registered dual read ports, write-first bypass
// and a sequential clear engine that sweeps one register per cycle.
module reg_bank_rw #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SP_IDX  = 29,
    parameter int unsigned SP_INIT = 227
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam logic [4:0]        SP_ADDR = 5'(SP_IDX);
    localparam logic [DATA_W-1:0] SP_VAL  = DATA_W'(SP_INIT);

    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] regs_d [32];
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic              wr_ok;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        regs_d    = regs_q;
        rs_data_d = regs_q[rs_addr];
        rt_data_d = regs_q[rt_addr];
        wr_ok     = 1'b0;

        unique case (state_q)
            IDLE: begin
                wr_ok = wr_en && (wr_addr != '0);
                if (wr_ok) begin
                    regs_d[wr_addr] = wr_data;
                    // Write-first: a read of the index being written sees the new data.
                    if (rs_addr == wr_addr) rs_data_d = wr_data;
                    if (rt_addr == wr_addr) rt_data_d = wr_data;
                end
                // A coincident write still commits; the sweep overwrites it later.
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                regs_d[cnt_q] = (cnt_q == SP_ADDR) ? SP_VAL : '0;
                cnt_d         = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= (5'(i) == SP_ADDR) ? SP_VAL : '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rs_data = rs_data_q;
    assign rt_data = rt_data_q;
    assign busy    = (state_q == CLEAR);

endmodule

// File: tb/tb_reg_bank_rw.sv
// Directed bench for reg_bank_rw: reset values, write/read, bypass, register 0,
// clear sweep timing, mid-clear reset and write coincident with a clear.
module tb_reg_bank_rw;

    logic        clk;
    logic        reset_n;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        clr_req;
    logic        busy;

    int checks;
    int fails;
    int busy_cycles;

    reg_bank_rw #(
        .DATA_W (32),
        .SP_IDX (29),
        .SP_INIT(227)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .rs_addr(rs_addr),
        .rt_addr(rt_addr),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .clr_req(clr_req),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        checks  = 0;
        fails   = 0;
        reset_n = 1'b0;
        rs_addr = 5'd29;
        rt_addr = 5'd0;
        wr_en   = 1'b0;
        wr_addr = 5'd0;
        wr_data = '0;
        clr_req = 1'b0;

        // Reset state
        #22;
        chk("rst_rs", rs_data, 32'd0);
        chk("rst_rt", rt_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        chk("post_rst_sp", rs_data, 32'd227);
        chk("post_rst_r0", rt_data, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // Plain write then read
        wr(5'd31, 32'h0000_1234);
        rs_addr = 5'd31;
        tick();
        chk("wr_rd_r31", rs_data, 32'h0000_1234);

        // Bypass on both ports
        rs_addr = 5'd8;
        rt_addr = 5'd8;
        wr(5'd8, 32'hDEAD_BEEF);
        chk("byp_rs", rs_data, 32'hDEAD_BEEF);
        chk("byp_rt", rt_data, 32'hDEAD_BEEF);

        // Register 0 write discarded, including bypass
        rs_addr = 5'd0;
        wr(5'd0, 32'hFFFF_FFFF);
        chk("r0_byp", rs_data, 32'd0);
        chk("r0_other", rt_data, 32'hDEAD_BEEF);
        tick();
        chk("r0_arr", rs_data, 32'd0);

        // Single-port bypass: rt keeps array value
        rs_addr = 5'd10;
        rt_addr = 5'd8;
        wr(5'd10, 32'hA5A5_0001);
        chk("byp1_rs", rs_data, 32'hA5A5_0001);
        chk("byp1_rt", rt_data, 32'hDEAD_BEEF);

        // Clear sequence
        wr(5'd5, 32'd7);
        wr(5'd29, 32'h100);
        rs_addr = 5'd5;
        rt_addr = 5'd29;
        tick();
        chk("pre_clr_r5", rs_data, 32'd7);
        chk("pre_clr_r29", rt_data, 32'h100);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("clr_busy_rise", {31'd0, busy}, 32'd1);
        busy_cycles = busy ? 1 : 0;
        for (int i = 1; i < 60; i++) begin
            wr_en   = (i == 1);
            wr_addr = 5'd5;
            wr_data = 32'd9;
            clr_req = (i == 3);
            tick();
            if (i == 2) chk("clr_wr_dropped", rs_data, 32'd7);
            if (!busy) break;
            busy_cycles++;
        end
        wr_en   = 1'b0;
        clr_req = 1'b0;
        chk("clr_busy_len", busy_cycles, 32'd32);
        tick();
        chk("clr_r5", rs_data, 32'd0);
        chk("clr_r29", rt_data, 32'd227);
        rs_addr = 5'd31;
        rt_addr = 5'd8;
        tick();
        chk("clr_r31", rs_data, 32'd0);
        chk("clr_r8", rt_data, 32'd0);

        // Mid-clear reset
        rs_addr = 5'd29;
        rt_addr = 5'd31;
        wr(5'd31, 32'h77);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        chk("mid_busy_pre", {31'd0, busy}, 32'd1);
        chk("mid_rs_pre", rs_data, 32'd227);
        reset_n = 1'b0;
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_rs", rs_data, 32'd0);
        chk("mid_rt", rt_data, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        chk("mid_r29", rs_data, 32'd227);
        chk("mid_r31", rt_data, 32'd0);
        rs_addr = 5'd12;
        wr(5'd12, 32'h55);
        tick();
        chk("mid_wr_r12", rs_data, 32'h55);
        chk("mid_idle", {31'd0, busy}, 32'd0);

        // Write coincident with clear start
        rs_addr = 5'd3;
        rt_addr = 5'd3;
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'd5;
        clr_req = 1'b1;
        tick();
        wr_en   = 1'b0;
        clr_req = 1'b0;
        chk("sim_byp", rs_data, 32'd5);
        chk("sim_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("sim_r3_ahead", rt_data, 32'd5);
        busy_cycles = 2;
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            tick();
            busy_cycles++;
        end
        chk("sim_busy_done", {31'd0, busy}, 32'd0);
        chk("sim_busy_len", busy_cycles, 32'd33);
        tick();
        chk("sim_r3_cleared", rs_data, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/reg_bank_rw.md
Name: reg_bank_rw

Overview:
- 32-entry general-purpose register file for the multicycle CPU.
- The write side consumes the destination index chosen by the register-destination select logic: rd, rt, 29 (sp) or 31 (ra).
- The read side supplies rs/rt operands to the A/B operand registers with one-cycle registered latency.
- A built-in sequential clear engine re-initialises the bank on request, e.g. for a soft CPU restart.

Parameters:
- DATA_W, 32, register and data width in bits.
- SP_IDX, 29, index of the stack-pointer register.
- SP_INIT, 227, reset and clear value loaded into register SP_IDX.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- rs_addr  input  5  read port A index.
- rt_addr  input  5  read port B index.
- rs_data  output  DATA_W  registered read data, port A.
- rt_data  output  DATA_W  registered read data, port B.
- wr_en  input  1  write strobe.
- wr_addr  input  5  write index, driven by the destination-select mux.
- wr_data  input  DATA_W  write data.
- clr_req  input  1  single-cycle pulse that starts a full-bank clear.
- busy  output  1  high while a clear is in progress.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All registers are 0, except reg[SP_IDX]=SP_INIT.
  - rs_data=0, rt_data=0, busy=0.
  - FSM goes to IDLE; clear counter=0.
- Register 0:
  - Always reads 0.
  - Writes to index 0 are discarded, including via bypass.
- Write path, in IDLE only:
  - On a clk edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data.
  - The new value is visible in the array the next cycle.
- Read path, 1-cycle latency:
  - Each clk edge: rs_data <= value(rs_addr), rt_data <= value(rt_addr).
  - Reads are registered every cycle; there is no read enable.
- Bypass (write-first):
  - Applies in IDLE when wr_en=1, wr_addr!=0 and wr_addr equals a read index in the same cycle.
  - That port captures wr_data, not the old array value.
  - If both read indices equal wr_addr, both ports bypass.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_req=1. busy rises on the same edge; counter=0.
  - CLEAR: each cycle writes reg[counter] <= (counter==SP_IDX ? SP_INIT : 0), then counter increments.
  - CLEAR -> IDLE after the edge that writes index 31. busy falls on that edge.
  - busy is therefore high for exactly 32 cycles.
- While busy:
  - wr_en is ignored; the write is dropped and not queued.
  - clr_req is ignored.
  - Reads still operate and return the current, possibly partially cleared, array contents. No bypass.
- Simultaneous clr_req and wr_en in IDLE:
  - The write commits on that edge.
  - The clear starts on the same edge, and its sweep later overwrites the written register.
- reset_n asserted mid-clear: immediate return to the reset state. The clear is not resumed.
- Counter is 5 bits; no wrap beyond 31 is ever observed.
- Index widths are fixed at 5 bits; all 32 indices are valid.

Test Plan:
- Reset then read:
  - Release reset_n with rs_addr=29, rt_addr=0.
  - -> After 1 edge: rs_data=227, rt_data=0; busy=0.
- Write/read:
  - wr_en=1, wr_addr=31, wr_data=0x0000_1234.
  - Next cycle rs_addr=31.
  - -> rs_data=0x0000_1234 one edge later.
- Bypass and reg0:
  - Same cycle: wr_en=1, wr_addr=8, wr_data=0xDEADBEEF, rs_addr=rt_addr=8.
  - -> Both outputs 0xDEADBEEF after that edge.
  - Then wr_addr=0, wr_data=0xFFFF_FFFF with rs_addr=0.
  - -> rs_data=0.
- Clear sequence:
  - Preload reg5=7 and reg29=0x100; pulse clr_req.
  - -> busy high exactly 32 cycles.
  - -> wr_en=1 to reg5 (data 9) during busy is dropped.
  - -> After busy falls: reg5 reads 0, reg29 reads 227.
- Mid-clear reset:
  - Assert reset_n=0 on clear cycle 10.
  - -> busy=0 and outputs 0 immediately; reg29=227.
  - -> Next writes in IDLE commit normally.
- Simultaneous write and clear:
  - In IDLE, clr_req=1 with wr_en=1, wr_addr=3, wr_data=5.
  - -> reg3 reads 5 while still ahead of the sweep, reads 0 after the clear completes.
